// File: rtl/sprite_palette_pkg.sv
// Shared types and reset contents for the sprite palette bank.
// The default palette is 12-bit RGB (4 bits per channel).
package sprite_palette_pkg;

  localparam int DEF_ENTRIES = 8;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WHITE  = 2'd1,
    NORMAL = 2'd2
  } flash_state_t;

  localparam rgb_t DEFAULT_PAL [DEF_ENTRIES] = '{
    12'h000, 12'h0E0, 12'h721, 12'hECA,
    12'h05E, 12'hE30, 12'h070, 12'h027
  };

  // Entries beyond the eight defaults come out of reset black.
  function automatic rgb_t default_entry(input int idx);
    logic [2:0] sel;
    sel = idx[2:0];
    return (idx < DEF_ENTRIES) ? DEFAULT_PAL[sel] : rgb_t'(12'h000);
  endfunction

endpackage

// File: rtl/palette_flash_ctrl.sv
// Frame-timed hit-flash sequencer: alternates WHITE/NORMAL phases of
// FLASH_HALF frames each for a programmable number of frames.
module palette_flash_ctrl
  import sprite_palette_pkg::*;
#(
  parameter int FLASH_HALF  = 4,
  parameter int FLASH_CNT_W = 6
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_tick,
  input  logic                   flash_start,
  input  logic [FLASH_CNT_W-1:0] flash_frames,
  output logic                   flash_white,
  output logic                   flash_active
);

  localparam int PHASE_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(FLASH_HALF - 1);
  localparam logic [FLASH_CNT_W-1:0] ONE_FRAME = FLASH_CNT_W'(1);

  flash_state_t           state, state_next;
  logic [FLASH_CNT_W-1:0] frames_left, frames_left_next;
  logic [PHASE_W-1:0]     phase_cnt, phase_cnt_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      frames_left <= '0;
      phase_cnt   <= '0;
    end else begin
      state       <= state_next;
      frames_left <= frames_left_next;
      phase_cnt   <= phase_cnt_next;
    end
  end

  // A valid start (non-zero duration) always wins over a same-cycle frame tick.
  always_comb begin
    state_next       = state;
    frames_left_next = frames_left;
    phase_cnt_next   = phase_cnt;
    if (flash_start && (flash_frames != '0)) begin
      state_next       = WHITE;
      frames_left_next = flash_frames;
      phase_cnt_next   = '0;
    end else if ((state != IDLE) && frame_tick) begin
      frames_left_next = frames_left - ONE_FRAME;
      if (phase_cnt == PHASE_LAST) begin
        phase_cnt_next = '0;
        state_next     = (state == WHITE) ? NORMAL : WHITE;
      end else begin
        phase_cnt_next = phase_cnt + PHASE_W'(1);
      end
      if (frames_left == ONE_FRAME) begin
        state_next     = IDLE;
        phase_cnt_next = '0;
      end
    end
  end

  assign flash_white  = (state == WHITE);
  assign flash_active = (state != IDLE);

endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-bank runtime-writable sprite palette with a 2-stage registered
// lookup pipeline and a frame-timed white hit-flash.
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int INDEX_W     = 3,
  parameter int NUM_BANKS   = 4,
  parameter int COLOR_W     = 4,
  parameter int FLASH_HALF  = 4,
  parameter int FLASH_CNT_W = 6,
  // May be widened beyond the minimum so bank selects can carry unused codes.
  parameter int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_tick,
  input  logic                   pix_valid_in,
  input  logic [INDEX_W-1:0]     index,
  input  logic [BANK_W-1:0]      bank_sel,
  input  logic                   wr_en,
  input  logic [BANK_W-1:0]      wr_bank,
  input  logic [INDEX_W-1:0]     wr_index,
  input  logic [3*COLOR_W-1:0]   wr_color,
  input  logic                   flash_start,
  input  logic [FLASH_CNT_W-1:0] flash_frames,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   pix_valid_out,
  output logic                   transparent,
  output logic                   flash_active
);

  localparam int ENTRIES    = 2 ** INDEX_W;
  localparam int PIX_W      = 3 * COLOR_W;
  localparam int BANK_IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [PIX_W-1:0]      pal [NUM_BANKS][ENTRIES];
  logic                  rd_in_range, wr_in_range;
  logic [BANK_IDX_W-1:0] rd_bank, wr_bank_idx;
  logic                  flash_white;

  logic                  s1_valid;
  logic                  s1_transparent;
  logic [PIX_W-1:0]      s1_color;

  function automatic logic [PIX_W-1:0] default_color(input int e);
    rgb_t c;
    c = default_entry(e);
    return {COLOR_W'(c.r), COLOR_W'(c.g), COLOR_W'(c.b)};
  endfunction

  assign rd_bank     = bank_sel[BANK_IDX_W-1:0];
  assign wr_bank_idx = wr_bank[BANK_IDX_W-1:0];

  // Only build the range compare when the select can encode a missing bank.
  if ((2 ** BANK_W) > NUM_BANKS) begin : g_range_check
    assign rd_in_range = (int'(bank_sel) < NUM_BANKS);
    assign wr_in_range = (int'(wr_bank) < NUM_BANKS);
  end else begin : g_all_banks_exist
    assign rd_in_range = 1'b1;
    assign wr_in_range = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          pal[b][e] <= default_color(e);
        end
      end
    end else if (wr_en && wr_in_range) begin
      pal[wr_bank_idx][wr_index] <= wr_color;
    end
  end

  // Stage 1 reads the pre-write array contents, so a same-cycle write is not seen.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid       <= 1'b0;
      s1_transparent <= 1'b0;
      s1_color       <= '0;
    end else begin
      s1_valid       <= pix_valid_in;
      s1_transparent <= (index == '0) || !rd_in_range;
      s1_color       <= rd_in_range ? pal[rd_bank][index] : '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_valid_out <= 1'b0;
      transparent   <= 1'b0;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
    end else begin
      pix_valid_out <= s1_valid;
      if (s1_valid) begin
        transparent <= s1_transparent;
        if (flash_white && !s1_transparent) begin
          {red, green, blue} <= '1;
        end else begin
          {red, green, blue} <= s1_color;
        end
      end
    end
  end

  palette_flash_ctrl #(
    .FLASH_HALF  (FLASH_HALF),
    .FLASH_CNT_W (FLASH_CNT_W)
  ) u_flash (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .flash_start  (flash_start),
    .flash_frames (flash_frames),
    .flash_white  (flash_white),
    .flash_active (flash_active)
  );

endmodule
